// File: rtl/ksa_pkg.sv
// Shared definitions for the pipelined Kogge-Stone add/subtract unit:
// operation encoding, prefix level count and the level-to-stage mapping.
package ksa_pkg;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      ADC = 2'd2,
      SBB = 2'd3
   } op_e;

   // Number of Kogge-Stone levels for a power-of-two width.
   function automatic int ksa_levels(input int width);
      return $clog2(width);
   endfunction

   // Stage that evaluates prefix level lvl. Levels are shared evenly and the
   // remainder lands in the last stage; with more stages than levels the
   // early stages are pure operand registers and the last one does all levels.
   function automatic int level_stage(input int lvl, input int levels, input int stages);
      int per;
      per = levels / stages;
      if (per == 0) return stages - 1;
      if ((lvl / per) > (stages - 1)) return stages - 1;
      return lvl / per;
   endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One combinational Kogge-Stone level: combines each (g,p) pair with the pair
// DIST positions below it. Positions below DIST are already complete groups.
module ksa_prefix_level #(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] g_in,
   input  logic [WIDTH-1:0] p_in,
   output logic [WIDTH-1:0] g_out,
   output logic [WIDTH-1:0] p_out
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         if (gi >= DIST) begin : g_comb
            assign g_out[gi] = g_in[gi] | (p_in[gi] & g_in[gi-DIST]);
            assign p_out[gi] = p_in[gi] & p_in[gi-DIST];
         end else begin : g_pass
            assign g_out[gi] = g_in[gi];
            assign p_out[gi] = p_in[gi];
         end
      end
   endgenerate

endmodule

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone add/subtract unit with valid/ready handshake.
// Optional build macro KSA_PIPE_SAT_EN adds a 'sat' input that clamps
// signed-overflowing results to the signed limit.
module ksa_pipe
   import ksa_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [1:0]       op,
`ifdef KSA_PIPE_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int LEVELS = ksa_levels(WIDTH);

   op_e              op_sel;
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic [WIDTH-1:0] pre_g;
   logic [WIDTH-1:0] pre_p;
   logic [WIDTH-1:0] pre_g_fold;
   logic             pre_sat;
   logic             advance;

   logic             out_valid_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;
   logic             ovf_reg;
   logic             zero_reg;

   assign op_sel = op_e'(op);

`ifdef KSA_PIPE_SAT_EN
   assign pre_sat = sat;
`else
   assign pre_sat = 1'b0;
`endif

   // Subtraction is a + ~b + 1; the op picks the inverted operand and carry-in.
   always_comb begin
      b_eff = b;
      c0    = 1'b0;
      case (op_sel)
         ADD: ;
         SUB: begin b_eff = ~b; c0 = 1'b1; end
         ADC: c0 = cin;
         SBB: begin b_eff = ~b; c0 = ~cin; end
         default: ;
      endcase
   end

   assign pre_g = a & b_eff;
   assign pre_p = a ^ b_eff;
   // Folding c0 into bit 0 makes every group generate a true carry, so
   // clog2(WIDTH) levels are enough to reach carry[WIDTH].
   assign pre_g_fold = {pre_g[WIDTH-1:1], pre_g[0] | (pre_p[0] & c0)};

   // Global stall: every stage moves when the output slot is free or drained.
   assign advance  = ~out_valid_reg | out_ready;
   assign in_ready = advance;

   genvar gi, gk;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic             st_valid;
         logic             st_c0;
         logic             st_sign;
         logic             st_sat;
         logic [WIDTH-1:0] st_p0;
         logic [WIDTH-1:0] ch_g [0:LEVELS];
         logic [WIDTH-1:0] ch_p [0:LEVELS];

         if (gi == 0) begin : g_src
            assign st_valid = in_valid;
            assign st_c0    = c0;
            assign st_sign  = a[WIDTH-1];
            assign st_sat   = pre_sat;
            assign st_p0    = pre_p;
            assign ch_g[0]  = pre_g_fold;
            assign ch_p[0]  = pre_p;
         end else begin : g_src
            assign st_valid = g_stage[gi-1].g_pipe.valid_reg;
            assign st_c0    = g_stage[gi-1].g_pipe.c0_reg;
            assign st_sign  = g_stage[gi-1].g_pipe.sign_reg;
            assign st_sat   = g_stage[gi-1].g_pipe.sat_reg;
            assign st_p0    = g_stage[gi-1].g_pipe.p0_reg;
            assign ch_g[0]  = g_stage[gi-1].g_pipe.gen_reg;
            assign ch_p[0]  = g_stage[gi-1].g_pipe.prop_reg;
         end

         for (gk = 0; gk < LEVELS; gk++) begin : g_lvl
            if (level_stage(gk, LEVELS, STAGES) == gi) begin : g_on
               ksa_prefix_level #(
                  .WIDTH (WIDTH),
                  .DIST  (1 << gk)
               ) u_level (
                  .g_in  (ch_g[gk]),
                  .p_in  (ch_p[gk]),
                  .g_out (ch_g[gk+1]),
                  .p_out (ch_p[gk+1])
               );
            end else begin : g_off
               assign ch_g[gk+1] = ch_g[gk];
               assign ch_p[gk+1] = ch_p[gk];
            end
         end

         if (gi < STAGES - 1) begin : g_pipe
            logic             valid_reg;
            logic             c0_reg;
            logic             sign_reg;
            logic             sat_reg;
            logic [WIDTH-1:0] p0_reg;
            logic [WIDTH-1:0] gen_reg;
            logic [WIDTH-1:0] prop_reg;

            // Intermediate stage register; reset drops whatever is in flight.
            always_ff @(posedge clk) begin
               if (rst) begin
                  valid_reg <= 1'b0;
                  c0_reg    <= 1'b0;
                  sign_reg  <= 1'b0;
                  sat_reg   <= 1'b0;
                  p0_reg    <= '0;
                  gen_reg   <= '0;
                  prop_reg  <= '0;
               end else if (advance) begin
                  valid_reg <= st_valid;
                  c0_reg    <= st_c0;
                  sign_reg  <= st_sign;
                  sat_reg   <= st_sat;
                  p0_reg    <= st_p0;
                  gen_reg   <= ch_g[LEVELS];
                  prop_reg  <= ch_p[LEVELS];
               end
            end
         end else begin : g_out
            logic [WIDTH-1:0] carry;
            logic [WIDTH-1:0] raw_sum;
            logic [WIDTH-1:0] res_sum;
            logic             raw_cout;
            logic             raw_ovf;
            logic             unused_prop;

            // Group generate i is the carry into bit i+1; c0 is carry[0].
            assign carry       = {ch_g[LEVELS][WIDTH-2:0], st_c0};
            assign raw_sum     = st_p0 ^ carry;
            assign raw_cout    = ch_g[LEVELS][WIDTH-1];
            assign raw_ovf     = ch_g[LEVELS][WIDTH-1] ^ ch_g[LEVELS][WIDTH-2];
            assign unused_prop = ^ch_p[LEVELS];

            // Saturation clamps toward the sign shared by both operands.
            always_comb begin
               res_sum = raw_sum;
               if (st_sat && raw_ovf) begin
                  res_sum = st_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
               end
            end

            // Output register; holds while the consumer stalls.
            always_ff @(posedge clk) begin
               if (rst) begin
                  out_valid_reg <= 1'b0;
                  sum_reg       <= '0;
                  cout_reg      <= 1'b0;
                  ovf_reg       <= 1'b0;
                  zero_reg      <= 1'b0;
               end else if (advance) begin
                  out_valid_reg <= st_valid;
                  sum_reg       <= res_sum;
                  cout_reg      <= raw_cout;
                  ovf_reg       <= raw_ovf;
                  zero_reg      <= ~|res_sum;
               end
            end
         end
      end
   endgenerate

   assign out_valid = out_valid_reg;
   assign sum       = sum_reg;
   assign cout      = cout_reg;
   assign ovf       = ovf_reg;
   assign zero      = zero_reg;

endmodule
